hud_pixel_mux: RTL

Per-pixel compositing stage downstream of the HUD text/digit renderers and the sprite renderers. It re-aligns the VGA driver's active-video flag to the renderers' registered lookup latency, resolves layer priority, and drives 24-bit RGB to the VGA output. It also owns the score-change flash effect: a frame-counted state machine that blinks the HUD text yellow after each score increment, changing colour only at frame boundaries.

---
 rtl/hud_pkg.sv | 19 +
 rtl/pipe_delay.sv | 25 ++
 rtl/hud_pixel_mux.sv | 120 ++++++++++++
 3 files changed

// File: rtl/hud_pkg.sv
// Shared types and constants for the HUD compositing path.
package hud_pkg;

    typedef logic [23:0] rgb_t;

    localparam rgb_t COLOR_WHITE  = 24'hFFFFFF;
    localparam rgb_t COLOR_YELLOW = 24'hFFFF00;
    localparam rgb_t COLOR_BLACK  = 24'h000000;

    typedef enum logic [1:0] {
        IDLE,
        ON,
        OFF
    } flash_state_t;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

endpackage

// File: rtl/pipe_delay.sv
// Fixed-depth shift-register delay line with synchronous active-high reset.
module pipe_delay #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] shift_q [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) shift_q[i] <= '0;
        end else begin
            shift_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) shift_q[i] <= shift_q[i-1];
        end
    end

    assign q_o = shift_q[DEPTH-1];

endmodule

// File: rtl/hud_pixel_mux.sv
// Per-pixel layer compositor with frame-synchronous score flash effect.
module hud_pixel_mux
    import hud_pkg::*;
#(
    parameter int   RENDER_LAT   = 1,
    parameter int   FLASH_FRAMES = 8,
    parameter int   FLASH_PHASES = 6,
    parameter rgb_t BG_COLOR     = COLOR_BLACK
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  x,
    input  logic [8:0]  y,
    input  logic        pix_valid,
    input  logic        txt_render,
    input  logic        digit_render,
    input  logic        sprite_render,
    input  logic [23:0] sprite_rgb,
    input  logic        score_inc,
    output logic [7:0]  r,
    output logic [7:0]  g,
    output logic [7:0]  b,
    output logic        rgb_valid,
    output logic        flashing
);

    localparam int FW = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;
    localparam int PW = $clog2(FLASH_PHASES);
    localparam logic [FW-1:0] FRAME_LAST = FW'(FLASH_FRAMES - 1);
    localparam logic [PW-1:0] PHASE_LAST = PW'(FLASH_PHASES - 1);

    flash_state_t  state_q;
    logic [FW-1:0] frame_cnt_q;
    logic [PW-1:0] phase_cnt_q;
    logic          pending_q;
    logic          flashing_q;
    logic          v_d;
    logic          tick;
    rgb_t          hud_rgb;
    rgb_t          rgb_d;
    rgb_t          rgb_q;
    logic          valid_q;

    assign tick = pix_valid && (x == 10'd0) && (y == 9'd0);

    pipe_delay #(
        .WIDTH (1),
        .DEPTH (RENDER_LAT)
    ) u_valid_dly (
        .clk   (clk),
        .reset (reset),
        .d_i   (pix_valid),
        .q_o   (v_d)
    );

    // A pulse arriving on the tick cycle itself starts the flash on that tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            frame_cnt_q <= '0;
            phase_cnt_q <= '0;
            pending_q   <= 1'b0;
            flashing_q  <= 1'b0;
        end else if (tick && (pending_q || score_inc)) begin
            state_q     <= ON;
            frame_cnt_q <= '0;
            phase_cnt_q <= '0;
            pending_q   <= 1'b0;
            flashing_q  <= 1'b1;
        end else begin
            if (score_inc) pending_q <= 1'b1;
            if (tick && (state_q != IDLE)) begin
                if (frame_cnt_q == FRAME_LAST) begin
                    frame_cnt_q <= '0;
                    if (phase_cnt_q == PHASE_LAST) begin
                        state_q     <= IDLE;
                        phase_cnt_q <= '0;
                        flashing_q  <= 1'b0;
                    end else begin
                        phase_cnt_q <= phase_cnt_q + 1'b1;
                        state_q     <= (state_q == ON) ? OFF : ON;
                    end
                end else begin
                    frame_cnt_q <= frame_cnt_q + 1'b1;
                end
            end
        end
    end

    always_comb begin
        case (state_q)
            ON:      hud_rgb = COLOR_YELLOW;
            OFF:     hud_rgb = BG_COLOR;
            default: hud_rgb = COLOR_WHITE;
        endcase
        rgb_d = '0;
        if (v_d) begin
            if (sprite_render)                   rgb_d = sprite_rgb;
            else if (txt_render || digit_render) rgb_d = hud_rgb;
            else                                 rgb_d = BG_COLOR;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rgb_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            rgb_q   <= rgb_d;
            valid_q <= v_d;
        end
    end

    assign r         = rgb_q[23:16];
    assign g         = rgb_q[15:8];
    assign b         = rgb_q[7:0];
    assign rgb_valid = valid_q;
    assign flashing  = flashing_q;

endmodule
